// File: rtl/fp_norm_round.sv
// fp_norm_round: post-add normalize, round-to-nearest-even and pack stage of the FP adder.
module fp_norm_round #(
  parameter int MAN_WIDTH = 11,
  parameter int EXP_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_WIDTH+2:0]   sum_in,
  input  logic                   carry_in,
  input  logic [EXP_WIDTH-1:0]   exp_in,
  input  logic                   sign_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign_out,
  output logic [EXP_WIDTH-1:0]   exp_out,
  output logic [MAN_WIDTH-2:0]   frac_out,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact
);
  localparam int SW = MAN_WIDTH + 3;
  localparam logic [EXP_WIDTH:0] EXP_ONE = 1;
  localparam logic [EXP_WIDTH:0] EXP_MAX = {1'b0, {EXP_WIDTH{1'b1}}};
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state, state_n;
  logic [SW-1:0] mant;
  logic [EXP_WIDTH:0] exp_r, exp_ld, exp_rnd;
  logic [MAN_WIDTH:0] rsum;
  logic sign_r, rup, inx, ovf, zero, at_top;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign zero = mant == '0;
  assign at_top = mant[SW-1] || exp_r == EXP_ONE;
  assign exp_ld = {1'b0, exp_in == '0 ? EXP_WIDTH'(1) : exp_in} + {{EXP_WIDTH{1'b0}}, carry_in};
  assign rup = mant[2] & (mant[1] | mant[0] | mant[3]);
  assign inx = |mant[2:0];
  // A carry out of the hidden bit bumps the exponent; a hidden bit still clear means subnormal.
  assign rsum = {1'b0, mant[SW-1:3]} + {{MAN_WIDTH{1'b0}}, rup};
  assign exp_rnd = rsum[MAN_WIDTH] ? exp_r + EXP_ONE : rsum[MAN_WIDTH-1] ? exp_r : '0;
  assign ovf = exp_rnd >= EXP_MAX;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? NORM : IDLE;
      NORM:    state_n = zero ? DONE : at_top ? ROUND : NORM;
      ROUND:   state_n = DONE;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mant <= '0;
      exp_r <= '0;
      sign_r <= 1'b0;
      sign_out <= 1'b0;
      exp_out <= '0;
      frac_out <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      inexact <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          mant <= carry_in ? {1'b1, sum_in[SW-1:2], |sum_in[1:0]} : sum_in;
          exp_r <= exp_ld;
          sign_r <= sign_in;
        end
        NORM: if (zero) begin
          sign_out <= sign_r;
          exp_out <= '0;
          frac_out <= '0;
          overflow <= 1'b0;
          underflow <= 1'b0;
          inexact <= 1'b0;
        end else if (!at_top) begin
          mant <= {mant[SW-2:0], 1'b0};
          exp_r <= exp_r - EXP_ONE;
        end
        ROUND: begin
          sign_out <= sign_r;
          exp_out <= ovf ? '1 : exp_rnd[EXP_WIDTH-1:0];
          frac_out <= ovf ? '0 : rsum[MAN_WIDTH-2:0];
          overflow <= ovf;
          inexact <= inx | ovf;
          underflow <= exp_rnd == '0 && inx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed and random checks of fp_norm_round against an arithmetic model.
module tb_fp_norm_round;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, carry_in = 0, sign_in = 0;
  logic [13:0] sum_in = '0;
  logic [4:0] exp_in = '0;
  logic in_ready, out_valid, sign_out, overflow, underflow, inexact;
  logic [4:0] exp_out;
  logic [9:0] frac_out;
  logic xs, xo, xu, xi;
  logic [4:0] xe;
  logic [9:0] xf;
  int xlat;
  int checks = 0, errors = 0;

  fp_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sum_in(sum_in),
    .carry_in(carry_in), .exp_in(exp_in), .sign_in(sign_in), .out_valid(out_valid),
    .out_ready(out_ready), .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, x, $time);
    end
  endtask

  // Value-level model: integer significand, count shifts, round by remainder.
  function automatic void model(input logic [13:0] s, input logic c, input logic [4:0] e,
                                output logic [4:0] oe, output logic [9:0] of, output logic oo,
                                output logic ou, output logic oi, output int lat);
    int m, ex, keep, rem;
    m = c ? (8192 | ((int'(s) >> 2) << 1) | ((s[1:0] != 0) ? 1 : 0)) : int'(s);
    ex = (e == 0 ? 1 : int'(e)) + (c ? 1 : 0);
    oo = 0; ou = 0; oi = 0;
    if (m == 0) begin
      oe = 0; of = 0; lat = 2;
      return;
    end
    lat = 3;
    while (m < 8192 && ex > 1) begin
      m = m * 2; ex--; lat++;
    end
    keep = m / 8; rem = m % 8; oi = rem != 0;
    if (rem > 4 || (rem == 4 && keep % 2 == 1)) keep++;
    if (keep >= 2048) begin keep = 0; ex++; end
    else if (keep < 1024) ex = 0;
    if (ex >= 31) begin ex = 31; keep = 0; oo = 1; oi = 1; end
    of = 10'(keep % 1024); oe = 5'(ex); ou = ex == 0 && oi;
  endfunction

  always @(negedge clk) if (!rst && out_valid) begin
    chk("sign_out", sign_out, xs);
    chk("exp_out", exp_out, xe);
    chk("frac_out", frac_out, xf);
    chk("overflow", overflow, xo);
    chk("underflow", underflow, xu);
    chk("inexact", inexact, xi);
  end

  task automatic start(input logic [13:0] s, input logic c, input logic [4:0] e, input logic sg);
    model(s, c, e, xe, xf, xo, xu, xi, xlat);
    xs = sg;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    sum_in = s; carry_in = c; exp_in = e; sign_in = sg; in_valid = 1; out_ready = 0;
    @(posedge clk);
  endtask

  task automatic run(input logic [13:0] s, input logic c, input logic [4:0] e, input logic sg,
                     input int hold, input int le, input int lf, input int lfl, input int llat);
    int n;
    bit seen;
    start(s, c, e, sg);
    seen = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      sum_in = 14'($urandom); carry_in = ~c; exp_in = 5'($urandom_range(1, 30)); sign_in = ~sg;
      if (out_valid) begin seen = 1; break; end
      chk("in_ready_busy", in_ready, 0);
    end
    in_valid = 0;
    chk("done_seen", 32'(seen), 1);
    chk("latency", n, xlat);
    if (le >= 0) chk("lit_exp", exp_out, le);
    if (lf >= 0) chk("lit_frac", frac_out, lf);
    if (lfl >= 0) chk("lit_flags", {overflow, underflow, inexact}, lfl);
    if (llat >= 0) chk("lit_latency", n, llat);
    repeat (hold) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("handoff_valid", out_valid, 0);
    chk("handoff_ready", in_ready, 1);
    chk("held_exp", exp_out, xe);
    chk("held_frac", frac_out, xf);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {sign_out, exp_out, frac_out, overflow, underflow, inexact}, 0);
    rst = 0;
    run(14'h0000, 1, 15, 0, 0, 16, 0, 0, 3);
    run(14'h0008, 0, 15, 1, 0, 5, 0, 0, 13);
    run(14'h200C, 0, 15, 0, 5, 15, 2, 1, 3);
    run(14'h2004, 0, 15, 1, 0, 15, 0, 1, 3);
    run(14'h3FFE, 0, 20, 0, 0, 21, 0, 1, 3);
    run(14'h0000, 1, 30, 0, 0, 31, 0, 5, 3);
    run(14'h0009, 0, 2, 0, 0, 0, 2, 3, 4);
    run(14'h0000, 0, 7, 1, 0, 0, 0, 0, 2);
    run(14'h0100, 0, 0, 0, 0, 0, 32, 0, 3);
    run(14'h0003, 1, 10, 0, 0, 11, 0, 1, 3);
    run(14'h000C, 1, 10, 1, 0, 11, 1, 1, 3);
    run(14'h3FFF, 1, 30, 0, 1, 31, 0, 5, 3);
    for (int i = 0; i < 12; i++)
      run(14'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)),
          1'($urandom_range(0, 1)), $urandom_range(0, 2), -1, -1, -1, -1);
    start(14'h0008, 0, 15, 1);
    repeat (4) @(negedge clk);
    in_valid = 0;
    chk("pre_rst_busy", in_ready, 0);
    rst = 1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_outputs", {sign_out, exp_out, frac_out, overflow, underflow, inexact}, 0);
    rst = 0;
    run(14'h2004, 0, 15, 1, 0, 15, 0, 1, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
Post-add normalize/round stage of the floating-point adder datapath. Consumes the raw mantissa sum and carry-out from the mantissa adder, plus the pre-add exponent and result sign. It normalizes the sum (right shift on carry, iterative left shift on cancellation), rounds to nearest-even, and packs sign/exponent/fraction. The block is multi-cycle, with valid/ready handshakes on both sides.

Parameters:
MAN_WIDTH, 11, significand width including the hidden bit (fraction is MAN_WIDTH-1 bits).
EXP_WIDTH, 5, biased exponent width.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input operands valid
in_ready  output  1  block can accept input
sum_in  input  MAN_WIDTH+3  adder sum: [MAN_WIDTH+2]=hidden, [MAN_WIDTH+1:3]=fraction, [2]=G, [1]=R, [0]=S
carry_in  input  1  adder carry-out
exp_in  input  EXP_WIDTH  biased exponent of larger operand
sign_in  input  1  result sign
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sign_out  output  1  result sign
exp_out  output  EXP_WIDTH  result biased exponent
frac_out  output  MAN_WIDTH-1  result fraction
overflow  output  1  result is infinity due to overflow
underflow  output  1  result subnormal/zero and inexact
inexact  output  1  any of G/R/S nonzero at rounding

Behaviour:
- Reset: state=IDLE. in_ready=1; out_valid=0; sign_out, exp_out, frac_out, overflow, underflow and inexact all 0. Reset in any state aborts the in-flight operation, and the result is discarded.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1 only in IDLE.
  - On in_valid&&in_ready, load the working registers:
    - if carry_in=1: mant = {1'b1, sum_in[MAN_WIDTH+2:1]}, with new S = sum_in[1]|sum_in[0]; exp = exp_in+1.
    - else: mant = sum_in; exp = exp_in.
  - exp_in=0 is treated as 1.
  - Next state is NORM.
- NORM (one decision per cycle):
  - mant==0: result is +/-zero (sign_in kept), exp=0 -> DONE.
  - else if mant[MSB]=1 or exp==1 -> ROUND.
  - else shift mant left by 1 (fill 0) and decrement exp; stay in NORM.
- ROUND:
  - Round to nearest-even: round_up = G & (R | S | frac LSB).
  - inexact = G|R|S.
  - Add round_up to {hidden, frac}:
    - If the add carries out of the hidden position: frac=0, exp+1.
    - If hidden was 0 (subnormal) and rounding sets it, exp_out=1.
  - Subnormal (hidden=0 after rounding): exp_out=0.
  - If the final exp equals all-ones: frac_out=0, exp_out=all-ones, overflow=1, inexact=1.
  - underflow = (exp_out==0) & inexact.
  - Next state is DONE.
- DONE:
  - out_valid=1; outputs held stable until out_ready=1, then -> IDLE.
  - Outputs remain registered (not cleared) after the handoff.
- Latency: accept edge = cycle 0 -> out_valid high at cycle 3+k, where k is the number of left shifts (k <= MAN_WIDTH+2). Zero result: out_valid at cycle 2.
- Throughput: one operation in flight. in_valid while busy is ignored (in_ready=0).
- Width rules: all exp arithmetic is EXP_WIDTH+1 bits internally to detect overflow. Inputs with exp_in all-ones (Inf/NaN) are handled upstream and are never driven.

Test Plan:
1. 1.0+1.0: exp_in=15, carry_in=1, sum_in=0 -> exp_out=16, frac_out=0, inexact=0, out_valid at cycle 3.
2. Cancellation: exp_in=15, carry_in=0, sum_in=14'h0008 -> 10 shifts; exp_out=5, frac_out=0, out_valid at cycle 13; in_ready=0 throughout.
3. RNE ties: hidden=1, frac=0x001, GRS=100 -> frac_out=0x002, inexact=1. Then frac=0x000, GRS=100 -> frac_out=0x000, inexact=1.
4. Rounding overflow: exp_in=20, hidden=1, frac=0x3FF, GRS=110 -> frac_out=0, exp_out=21. Then exp_in=30, carry_in=1 -> exp_out=31, frac_out=0, overflow=1.
5. Subnormal/zero: exp_in=2, sum_in with only frac bit0 set, GRS=001 -> shifts stop at exp=1; exp_out=0, underflow=1. Separately, sum_in=0, carry_in=0 -> exp_out=0, frac_out=0, out_valid at cycle 2.
6. Backpressure/reset:
   - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
   - Assert rst during NORM of scenario 2 -> next cycle state=IDLE, in_ready=1, out_valid=0, all outputs 0.
